fp_mac_sequencer: RTL and testbench

//  Control FSM for the FP MAC datapath (multiply -> align/add -> fr_normalize).
//  - Accepts one operand pair per valid/ready handshake and issues per-stage enables.
//  - Accumulates vec_len terms into the accumulator, then presents the result.
//  - Serialises the accumulator dependency: term k+1 is not added until term k has left normalize.

---
 rtl/fp_mac_pkg.sv | 24 ++
 rtl/fp_mac_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fp_mac_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mac_pkg.sv
// Shared definitions for the FP MAC datapath and its control sequencer.
// State encodings are kept here so the datapath stages and the sequencer
// agree on the meaning of each control phase.
package fp_mac_pkg;

    localparam int DEFAULT_LEN_W = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_ALIGN  = 3'd2;
    localparam logic [2:0] ST_ADD    = 3'd3;
    localparam logic [2:0] ST_NORM   = 3'd4;
    localparam logic [2:0] ST_RESULT = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        FETCH  = ST_FETCH,
        ALIGN  = ST_ALIGN,
        ADD    = ST_ADD,
        NORM   = ST_NORM,
        RESULT = ST_RESULT
    } state_t;

endpackage

// File: rtl/fp_mac_sequencer.sv
// Control FSM for the FP MAC datapath (multiply -> align/add -> normalize).
// One term is processed at a time: the next operand pair is not fetched
// until the previous term has written the accumulator in NORM, which
// removes the accumulator read-after-write hazard without forwarding.
module fp_mac_sequencer #(
    parameter int LEN_W    = fp_mac_pkg::DEFAULT_LEN_W,
    parameter int NORM_LAT = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             nor_ov_sig,
    output logic             mul_en,
    output logic             align_en,
    output logic             add_en,
    output logic             acc_sel_zero,
    output logic             norm_en,
    output logic [LEN_W-1:0] term_idx,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done,
    output logic             ovf_sticky
);

    import fp_mac_pkg::*;

    localparam int               CNT_W     = (NORM_LAT > 1) ? $clog2(NORM_LAT) : 1;
    localparam logic [CNT_W-1:0] NORM_LAST = CNT_W'(NORM_LAT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] term_idx_q;
    logic [LEN_W-1:0] term_idx_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic [CNT_W-1:0] norm_cnt_q;
    logic [CNT_W-1:0] norm_cnt_d;
    logic             ovf_q;
    logic             ovf_d;

    // State and counter registers; reset discards any partial accumulation.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            term_idx_q <= '0;
            len_q      <= '0;
            norm_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            term_idx_q <= term_idx_d;
            len_q      <= len_d;
            norm_cnt_q <= norm_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state and counter update; abort overrides every other transition.
    always_comb begin
        state_d    = state_q;
        term_idx_d = term_idx_q;
        len_d      = len_q;
        norm_cnt_d = norm_cnt_q;
        ovf_d      = ovf_q;
        if (abort) begin
            state_d    = IDLE;
            term_idx_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_d      = vec_len;
                        ovf_d      = 1'b0;
                        term_idx_d = '0;
                        state_d    = (vec_len == '0) ? RESULT : FETCH;
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        state_d = ALIGN;
                    end
                end
                ALIGN: begin
                    state_d = ADD;
                end
                ADD: begin
                    state_d    = NORM;
                    norm_cnt_d = '0;
                end
                NORM: begin
                    if (norm_cnt_q == NORM_LAST) begin
                        ovf_d = ovf_q | nor_ov_sig;
                        if (term_idx_q == len_q - 1'b1) begin
                            state_d = RESULT;
                        end else begin
                            term_idx_d = term_idx_q + 1'b1;
                            state_d    = FETCH;
                        end
                    end else begin
                        norm_cnt_d = norm_cnt_q + 1'b1;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state_d    = IDLE;
                        term_idx_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Stage enables decoded from the registered state; only the FETCH handshake and done look at inputs.
    always_comb begin
        in_ready     = 1'b0;
        mul_en       = 1'b0;
        align_en     = 1'b0;
        add_en       = 1'b0;
        acc_sel_zero = 1'b0;
        norm_en      = 1'b0;
        out_valid    = 1'b0;
        done         = 1'b0;
        case (state_q)
            FETCH: begin
                in_ready = !abort;
                mul_en   = in_valid && !abort;
            end
            ALIGN: begin
                align_en = 1'b1;
            end
            ADD: begin
                add_en       = 1'b1;
                acc_sel_zero = (term_idx_q == '0);
            end
            NORM: begin
                norm_en = 1'b1;
            end
            RESULT: begin
                out_valid    = 1'b1;
                acc_sel_zero = (len_q == '0);
                done         = out_ready && !abort;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign term_idx   = term_idx_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_fp_mac_sequencer.sv
// Directed, self-checking bench for fp_mac_sequencer.
// A cycle table covers a full 3-term accumulation; hand-written sequences
// cover stalls, empty vectors, overflow stickiness, abort, reset and NORM_LAT=3.
module tb_fp_mac_sequencer;

    // Flag vector order: in_ready, mul_en, align_en, add_en, acc_sel_zero,
    // norm_en, busy, out_valid, done, ovf_sticky.
    localparam logic [9:0] F_ZERO      = 10'b0000000000;
    localparam logic [9:0] F_FETCH     = 10'b1100001000;
    localparam logic [9:0] F_WAIT      = 10'b1000001000;
    localparam logic [9:0] F_BUSY      = 10'b0000001000;
    localparam logic [9:0] F_ALIGN     = 10'b0010001000;
    localparam logic [9:0] F_ADD0      = 10'b0001101000;
    localparam logic [9:0] F_ADD       = 10'b0001001000;
    localparam logic [9:0] F_NORM      = 10'b0000011000;
    localparam logic [9:0] F_DONE      = 10'b0000001110;
    localparam logic [9:0] F_RES0      = 10'b0000101100;
    localparam logic [9:0] F_RES0_DONE = 10'b0000101110;
    localparam logic [9:0] F_RES_OVF   = 10'b0000001101;
    localparam logic [9:0] F_DONE_OVF  = 10'b0000001111;
    localparam logic [9:0] F_IDLE_OVF  = 10'b0000000001;
    localparam logic [9:0] F_FETCH_OVF = 10'b1100001001;

    typedef struct {
        logic       start;
        logic [7:0] vec_len;
        logic       in_valid;
        logic       out_ready;
        logic       abort;
        logic       nor_ov_sig;
        logic [9:0] flags;
        logic [7:0] idx;
    } vec_t;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [7:0] vec_len;
    logic       abort;
    logic       in_valid;
    logic       out_ready;
    logic       nor_ov_sig;

    logic       in_ready,  mul_en,  align_en,  add_en,  acc_sel_zero,  norm_en;
    logic       busy,  out_valid,  done,  ovf_sticky;
    logic [7:0] term_idx;
    logic       in_ready3, mul_en3, align_en3, add_en3, acc_sel_zero3, norm_en3;
    logic       busy3, out_valid3, done3, ovf_sticky3;
    logic [7:0] term_idx3;

    logic [17:0] obs;
    logic [17:0] obs3;

    int checks = 0;
    int fails  = 0;

    vec_t tbl [15];

    assign obs  = {in_ready, mul_en, align_en, add_en, acc_sel_zero, norm_en,
                   busy, out_valid, done, ovf_sticky, term_idx};
    assign obs3 = {in_ready3, mul_en3, align_en3, add_en3, acc_sel_zero3, norm_en3,
                   busy3, out_valid3, done3, ovf_sticky3, term_idx3};

    fp_mac_sequencer #(.LEN_W(8), .NORM_LAT(1)) dut (
        .clock(clock), .resetn(resetn), .start(start), .vec_len(vec_len),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .nor_ov_sig(nor_ov_sig), .mul_en(mul_en), .align_en(align_en),
        .add_en(add_en), .acc_sel_zero(acc_sel_zero), .norm_en(norm_en),
        .term_idx(term_idx), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .done(done), .ovf_sticky(ovf_sticky)
    );

    fp_mac_sequencer #(.LEN_W(8), .NORM_LAT(3)) dut3 (
        .clock(clock), .resetn(resetn), .start(start), .vec_len(vec_len),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready3),
        .nor_ov_sig(nor_ov_sig), .mul_en(mul_en3), .align_en(align_en3),
        .add_en(add_en3), .acc_sel_zero(acc_sel_zero3), .norm_en(norm_en3),
        .term_idx(term_idx3), .busy(busy3), .out_valid(out_valid3),
        .out_ready(out_ready), .done(done3), .ovf_sticky(ovf_sticky3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs at the falling edge and let outputs settle.
    task automatic applyStimulus(input logic st, input logic [7:0] len, input logic iv,
                                 input logic ordy, input logic ab, input logic ov);
        @(negedge clock);
        start      = st;
        vec_len    = len;
        in_valid   = iv;
        out_ready  = ordy;
        abort      = ab;
        nor_ov_sig = ov;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [17:0] actual,
                               input logic [17:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got flags=%b idx=%0d, expected flags=%b idx=%0d",
                     name, actual[17:8], actual[7:0], expected[17:8], expected[7:0]);
        end
    endtask

    task automatic resetAll();
        @(negedge clock);
        resetn     = 1'b0;
        start      = 1'b0;
        vec_len    = 8'd0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        abort      = 1'b0;
        nor_ov_sig = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, F_ZERO,  8'd0};
        tbl[1]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, F_FETCH, 8'd0};
        tbl[2]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, F_ALIGN, 8'd0};
        tbl[3]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, F_ADD0,  8'd0};
        tbl[4]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, F_NORM,  8'd0};
        tbl[5]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, F_FETCH, 8'd1};
        tbl[6]  = '{1'b1, 8'd9, 1'b1, 1'b1, 1'b0, 1'b0, F_ALIGN, 8'd1};
        tbl[7]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, F_ADD,   8'd1};
        tbl[8]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, F_NORM,  8'd1};
        tbl[9]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, F_FETCH, 8'd2};
        tbl[10] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, F_ALIGN, 8'd2};
        tbl[11] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, F_ADD,   8'd2};
        tbl[12] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, F_NORM,  8'd2};
        tbl[13] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, F_DONE,  8'd2};
        tbl[14] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, F_ZERO,  8'd0};

        resetn = 1'b1;
        resetAll();
        checkOutput("reset state", obs, 18'd0);
        checkOutput("reset state NORM_LAT=3", obs3, 18'd0);

        $display("[TB] vec_len=3 streaming accumulation");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].start, tbl[i].vec_len, tbl[i].in_valid,
                          tbl[i].out_ready, tbl[i].abort, tbl[i].nor_ov_sig);
            checkOutput($sformatf("table row %0d", i), obs, {tbl[i].flags, tbl[i].idx});
        end

        $display("[TB] vec_len=2 with FETCH stall");
        resetAll();
        applyStimulus(1, 8'd2, 1, 1, 0, 0);
        applyStimulus(0, 8'd0, 1, 1, 0, 0);
        checkOutput("stall term0 fetch", obs, {F_FETCH, 8'd0});
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'd0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 8'd0, 0, 1, 0, 0);
            checkOutput($sformatf("stall wait %0d", i), obs, {F_WAIT, 8'd1});
        end
        applyStimulus(0, 8'd0, 1, 1, 0, 0);
        checkOutput("stall handshake", obs, {F_FETCH, 8'd1});
        applyStimulus(0, 8'd0, 0, 1, 0, 0);
        checkOutput("stall align", obs, {F_ALIGN, 8'd1});
        applyStimulus(0, 8'd0, 0, 1, 0, 0);
        checkOutput("stall add", obs, {F_ADD, 8'd1});
        applyStimulus(0, 8'd0, 0, 1, 0, 0);
        checkOutput("stall norm", obs, {F_NORM, 8'd1});
        applyStimulus(0, 8'd0, 0, 1, 0, 0);
        checkOutput("stall result", obs, {F_DONE, 8'd1});
        applyStimulus(0, 8'd0, 0, 1, 0, 0);
        checkOutput("stall idle", obs, {F_ZERO, 8'd0});

        $display("[TB] vec_len=0 with held result");
        resetAll();
        applyStimulus(1, 8'd0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 8'd0, 0, 0, 0, 0);
            checkOutput($sformatf("len0 hold %0d", i), obs, {F_RES0, 8'd0});
        end
        applyStimulus(0, 8'd0, 0, 1, 0, 0);
        checkOutput("len0 done", obs, {F_RES0_DONE, 8'd0});
        applyStimulus(0, 8'd0, 0, 0, 0, 0);
        checkOutput("len0 idle", obs, {F_ZERO, 8'd0});

        $display("[TB] overflow stickiness over vec_len=4");
        resetAll();
        applyStimulus(1, 8'd4, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'd0, 1, 0, 0, 0);
        applyStimulus(0, 8'd0, 1, 0, 0, 1);
        checkOutput("ovf fetch flag ignored", obs, {F_FETCH, 8'd1});
        applyStimulus(0, 8'd0, 1, 0, 0, 0);
        checkOutput("ovf not set outside norm", obs, {F_ALIGN, 8'd1});
        applyStimulus(0, 8'd0, 1, 0, 0, 0);
        applyStimulus(0, 8'd0, 1, 0, 0, 1);
        checkOutput("ovf norm term1", obs, {F_NORM, 8'd1});
        applyStimulus(0, 8'd0, 1, 0, 0, 0);
        checkOutput("ovf set after norm", obs, {F_FETCH_OVF, 8'd2});
        for (int i = 0; i < 7; i++) applyStimulus(0, 8'd0, 1, 0, 0, 0);
        applyStimulus(0, 8'd0, 1, 0, 0, 0);
        checkOutput("ovf result held", obs, {F_RES_OVF, 8'd3});
        applyStimulus(0, 8'd0, 1, 1, 0, 0);
        checkOutput("ovf result done", obs, {F_DONE_OVF, 8'd3});
        applyStimulus(1, 8'd1, 1, 0, 0, 0);
        checkOutput("ovf kept in idle", obs, {F_IDLE_OVF, 8'd0});
        applyStimulus(0, 8'd0, 1, 0, 0, 0);
        checkOutput("ovf cleared by start", obs, {F_FETCH, 8'd0});

        $display("[TB] abort handling");
        resetAll();
        applyStimulus(1, 8'd5, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 8'd0, 1, 1, 0, 0);
        applyStimulus(0, 8'd0, 1, 1, 1, 0);
        checkOutput("abort in add term2", obs, {F_ADD, 8'd2});
        applyStimulus(0, 8'd0, 1, 1, 0, 0);
        checkOutput("abort back to idle", obs, {F_ZERO, 8'd0});
        applyStimulus(1, 8'd5, 1, 1, 0, 0);
        checkOutput("restart idle", obs, {F_ZERO, 8'd0});
        applyStimulus(0, 8'd0, 1, 1, 1, 0);
        checkOutput("abort in fetch", obs, {F_BUSY, 8'd0});
        applyStimulus(1, 8'd0, 0, 0, 0, 0);
        checkOutput("abort fetch idle", obs, {F_ZERO, 8'd0});
        applyStimulus(0, 8'd0, 0, 1, 1, 0);
        checkOutput("abort in result", obs, {F_RES0, 8'd0});
        applyStimulus(0, 8'd0, 0, 0, 0, 0);
        checkOutput("abort result idle", obs, {F_ZERO, 8'd0});

        $display("[TB] NORM_LAT=3 instance");
        resetAll();
        applyStimulus(1, 8'd1, 1, 1, 0, 0);
        applyStimulus(0, 8'd0, 1, 1, 0, 0);
        checkOutput("lat3 fetch", obs3, {F_FETCH, 8'd0});
        applyStimulus(0, 8'd0, 1, 1, 0, 0);
        checkOutput("lat3 align", obs3, {F_ALIGN, 8'd0});
        applyStimulus(0, 8'd0, 1, 1, 0, 0);
        checkOutput("lat3 add", obs3, {F_ADD0, 8'd0});
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 8'd0, 1, 1, 0, (i == 0) ? 1'b1 : 1'b0);
            checkOutput($sformatf("lat3 norm %0d", i), obs3, {F_NORM, 8'd0});
        end
        applyStimulus(0, 8'd0, 1, 1, 0, 0);
        checkOutput("lat3 result", obs3, {F_DONE, 8'd0});
        applyStimulus(0, 8'd0, 1, 1, 0, 0);
        checkOutput("lat3 idle", obs3, {F_ZERO, 8'd0});

        $display("[TB] asynchronous reset mid-NORM");
        resetAll();
        applyStimulus(1, 8'd2, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 8'd0, 1, 1, 0, 0);
        applyStimulus(0, 8'd0, 1, 1, 0, 0);
        checkOutput("pre-reset norm", obs, {F_NORM, 8'd1});
        resetn = 1'b0;
        #1;
        checkOutput("reset mid-norm immediate", obs, 18'd0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        checkOutput("after reset release", obs, 18'd0);
        applyStimulus(1, 8'd1, 1, 1, 0, 0);
        applyStimulus(0, 8'd0, 1, 1, 0, 0);
        checkOutput("restart after reset", obs, {F_FETCH, 8'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
